// File: rtl/mem_pkg.sv
// Shared encodings, state enum and store-lane helpers for the MEM-stage LSU.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Access size encodings; 2'd3 is reserved and handled as a word.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Instruction fields captured when MEM accepts from EX.
  typedef struct packed {
    logic              re;
    logic              we;
    logic              is_signed;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
  } inst_t;

  // Half needs addr[0]=0, word (and reserved) needs addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  // Byte-enable pattern for a store of the given size and offset.
  function automatic logic [STRB_W-1:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 4'b0001 << lo;
      SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes so strobes pick the right bytes.
  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size, input logic [DATA_W-1:0] w);
    case (size)
      SZ_B:    return {4{w[7:0]}};
      SZ_H:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: shifts the addressed bytes down and sign/zero-extends.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] sh;

  assign sh = rdata >> {addr_lo, 3'b000};

  // Select byte/half/word from the shifted word and extend.
  always_comb begin
    ext = sh;
    case (size)
      SZ_B:    ext = {{24{is_signed & sh[7]}}, sh[7:0]};
      SZ_H:    ext = {{16{is_signed & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding request on a req/addr_ok/data_ok bus,
// result presented with mem_ready_go only once final.
module mem_stage_lsu
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic              wb_allowin,
  output logic              mem_allowin,
  output logic              mem_valid,
  output logic              mem_ready_go,
  output logic [DATA_W-1:0] mem_rdata_ext,
  output logic              mem_ale,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [STRB_W-1:0] data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata
);

  state_e            state;
  state_e            state_nxt;
  inst_t             inst_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ale_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_ext;
  logic              accept;
  logic              ex_ale;
  logic              ex_issue;

  // Handshake with EX and classification of the incoming instruction.
  always_comb begin
    mem_allowin = (state == S_IDLE) || ((state == S_DONE) && wb_allowin);
    accept      = ex_valid && mem_allowin;
    ex_ale      = (ex_mem_re || ex_mem_we) && misaligned(ex_size, ex_addr[1:0]);
    ex_issue    = (ex_mem_re || ex_mem_we) && !ex_ale;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: aligned memory ops go to the bus, everything else finishes at once.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = ex_issue ? S_REQ : S_DONE;
      S_REQ:  if (data_sram_addr_ok) state_nxt = S_WAIT;
      S_WAIT: if (data_sram_data_ok) state_nxt = S_DONE;
      S_DONE: begin
        if (wb_allowin) begin
          if (accept) state_nxt = ex_issue ? S_REQ : S_DONE;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded status and bus request.
  always_comb begin
    mem_valid     = (state != S_IDLE);
    mem_ready_go  = (state == S_DONE);
    data_sram_req = (state == S_REQ);
  end

  // Latch instruction and precomputed store lanes on accept; bus fields hold until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ale_q   <= 1'b0;
    end else if (accept) begin
      inst_q.re        <= ex_mem_re;
      inst_q.we        <= ex_mem_we;
      inst_q.is_signed <= ex_signed;
      inst_q.size      <= ex_size;
      inst_q.addr      <= ex_addr;
      wstrb_q          <= ex_mem_we ? store_strb(ex_size, ex_addr[1:0]) : STRB_W'(0);
      wdata_q          <= store_data(ex_size, ex_wdata);
      ale_q            <= ex_ale;
    end
  end

  // Load result: cleared per instruction, captured when read data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= '0;
    end else if ((state == S_WAIT) && data_sram_data_ok && inst_q.re) begin
      rdata_q <= load_ext;
    end
  end

  lsu_load_align u_align (
    .rdata     (data_sram_rdata),
    .addr_lo   (inst_q.addr[1:0]),
    .size      (inst_q.size),
    .is_signed (inst_q.is_signed),
    .ext       (load_ext)
  );

  assign mem_rdata_ext   = rdata_q;
  assign mem_ale         = ale_q;
  assign data_sram_wr    = inst_q.we;
  assign data_sram_size  = inst_q.size;
  assign data_sram_addr  = inst_q.addr;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

MEM-stage load/store unit: accepts one memory instruction from EX, drives the SRAM-like data-memory bus (req/addr_ok/data_ok), and aligns and sign- or zero-extends load data. It asserts `mem_ready_go` only when the result is final, so the downstream MEM→WB register captures a stable value. It holds at most one outstanding transaction. Misaligned accesses are flagged and never issued on the bus.

## Interface
Parameters: none. Widths are fixed at 32-bit address and 32-bit data.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction
- ex_mem_re  in  1  instruction is a load
- ex_mem_we  in  1  instruction is a store
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data, right-aligned
- ex_size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- ex_signed  in  1  loads: 1 sign-extend, 0 zero-extend
- wb_allowin  in  1  WB accepts this cycle
- mem_allowin  out  1  MEM accepts from EX this cycle
- mem_valid  out  1  MEM holds an instruction
- mem_ready_go  out  1  result final; handoff occurs when `mem_ready_go && wb_allowin`
- mem_rdata_ext  out  32  aligned and extended load data (0 for non-loads)
- mem_ale  out  1  address misaligned
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  1 write, 0 read
- data_sram_size  out  2  latched size
- data_sram_addr  out  32  latched address
- data_sram_wstrb  out  4  byte strobes (0 on reads)
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  read data / write ack returned
- data_sram_rdata  in  32  read data

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Accept condition: `ex_valid && mem_allowin`, where `mem_allowin = (state==IDLE) || (state==DONE && wb_allowin)`. On accept, the unit latches addr, wdata, size, signed, re and we.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0, sets `mem_ale=1`.
- Transitions on accept:
  - Load or store and aligned → REQ.
  - Non-memory op or misaligned → DONE. No bus activity occurs.
- REQ: `data_sram_req=1`; all bus outputs stay stable until `addr_ok`. On `addr_ok` → WAIT.
- WAIT: `req=0`. On `data_ok` → DONE. For loads, `mem_rdata_ext` is registered from `data_sram_rdata`.
- DONE: `mem_valid=1`, `mem_ready_go=1`.
  - If `wb_allowin` and a new accept occurs, go directly to the new instruction's next state.
  - If `wb_allowin` and no accept, go to IDLE.
  - If `!wb_allowin`, hold all outputs.
- Store lanes:
  - Byte: `wstrb = 1<<addr[1:0]`, `wdata = {4{b}}`.
  - Half: `wstrb = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{h}}`.
  - Word: `wstrb = 4'b1111`.
- Load extraction: `sh = rdata >> (8*addr[1:0])`. Take bits [7:0] or [15:0] of `sh` and extend per `signed`.
- `data_ok` and `addr_ok` are ignored outside WAIT and REQ respectively.
- The bus slave shares `rst`, so no stale responses occur after reset.

## Timing
- Reset (any state, including mid-transaction): next state IDLE, `mem_allowin=1`, all other outputs 0. An in-flight request is abandoned.
- Minimum memory latency is 3 cycles:
  - Accept at cycle 0.
  - REQ at cycle 1, with `addr_ok` in the same cycle.
  - WAIT at cycle 2, with `data_ok` in the same cycle.
  - DONE at cycle 3.
- Each cycle of `addr_ok` or `data_ok` delay adds one cycle.
- Non-memory and misaligned ops reach DONE at cycle 1.
- Back-to-back: with `wb_allowin=1` held, a new instruction is accepted in the DONE cycle, with no bubble on the EX side.
- `data_ok` never coincides with the `addr_ok` of the same request; the earliest it can arrive is the following cycle.

## Structure
- Package `mem_pkg`: size encodings (SZ_B, SZ_H, SZ_W) and the state enum (S_IDLE, S_REQ, S_WAIT, S_DONE).
- Sub-module `lsu_load_align` (combinational): inputs rdata, addr[1:0], size and signed; output is the extended word. It is reused by any future uncached path.

## Test plan
- `lb`, addr 0x1003, signed, rdata 0x80_12_34_56; `addr_ok` at cycle 1, `data_ok` at cycle 2 → `mem_rdata_ext` = 0xFFFFFF80 with `mem_ready_go` at cycle 3.
- `sh`, addr 0x2002, wdata 0x0000BEEF → `req`, `wr=1`, `wstrb=4'b1100`, `wdata=0xBEEFBEEF`, held stable through 3 cycles of `addr_ok` low.
- `lw`, addr 0x3001 → `mem_ale=1`, `mem_ready_go` at cycle 1, `data_sram_req` never asserted.
- `lhu`, addr 0x4002, rdata 0xA5A5_0000 with `wb_allowin=0` for 4 cycles in DONE → outputs hold 0x0000A5A5; a following load is accepted in the cycle `wb_allowin` rises.
- `rst` asserted in WAIT → next cycle state IDLE, `req=0`, `mem_valid=0`, `mem_allowin=1`; a subsequent `lbu` at 0x5000 completes normally.
- 8 back-to-back `sw`/`lw` pairs with random `addr_ok`/`data_ok` delays of 0–3 cycles → every load returns the previously stored word, and exactly one request is outstanding at any time.
